// File: rtl/shift_add_multiplier_if.sv
// Handshake and operand/result bundle for shift_add_multiplier.
// Ports: start/a/b flow from requester to multiplier; ready/busy/done/p flow back.
// The master modport belongs to the requester and the slave modport to the multiplier.
interface shift_add_multiplier_if #(
  parameter int N = 8
);
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*N-1:0] p;

  modport master (
    output start, a, b,
    input  ready, busy, done, p
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, p
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// Purpose: iterative N-bit shift-and-add multiplier producing a 2N-bit product.
// Latency: N RUN cycles then a one-cycle DONE pulse, so one result per N+2 cycles.
// Backpressure: start is taken only while ready=1; it is ignored in RUN and DONE.
//
// Ports: clk (rising edge), rst (synchronous, active-high), bus (slave modport):
//   start/a/b in, ready (IDLE), busy (RUN), done (DONE pulse, p valid), p out.
// Option: define SHIFT_ADD_MULTIPLIER_SIGNED_EN for two's-complement operands;
//   otherwise a, b and p are unsigned. Timing and ports are identical either way.
module shift_add_multiplier #(
  parameter int N = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  shift_add_multiplier_if.slave  bus
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [2*N-1:0] mcand;     // multiplicand, shifted left to the current bit weight
  logic [N-1:0]   mplier;    // multiplier, shifted right so bit 0 is the current bit
  logic [2*N-1:0] acc;
  logic [2*N-1:0] acc_nxt;
  logic [2*N-1:0] addend;
  logic [2*N-1:0] p_q;
  logic [CW-1:0]  cnt;       // iterations remaining
  logic           last_iter;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*N-1:0] mcand_ext;

  assign last_iter = (cnt == CW'(1));

`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
  assign mcand_ext = {{N{bus.a[N-1]}}, bus.a};
`else
  assign mcand_ext = {{N{1'b0}}, bus.a};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and status outputs
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // One partial product per RUN cycle. In signed mode the multiplier MSB
  // carries weight -2^(N-1), so the final partial product is subtracted.
  always_comb begin
    addend  = mplier[0] ? mcand : '0;
    acc_nxt = acc + addend;
`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
    if (last_iter) begin
      acc_nxt = acc - addend;
    end
`endif
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      p_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= mcand_ext;
            mplier <= bus.b;
            acc    <= '0;
            cnt    <= CW'(N);
          end
        end
        RUN: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          // Result is registered on the edge that enters DONE and held afterwards.
          if (last_iter) begin
            p_q <= acc_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.ready = ready;
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.p     = p_q;

endmodule
